clock_freq_meter: RTL and testbench

//  Periodic consumer of a latch/valid clock-counter pair: requests a latch, waits for the snapshot,

---
 rtl/clock_freq_meter_pkg.sv | 21 ++
 rtl/clock_freq_meter_if.sv | 25 ++
 rtl/seq_divider.sv | 75 +++++++
 rtl/clock_freq_meter.sv | 149 ++++++++++++++
 tb/tb_clock_freq_meter.sv | 257 +++++++++++++++++++++++++
 5 files changed

// File: rtl/clock_freq_meter_pkg.sv
// Shared types and width helpers for the clock frequency meter and its divider.
// The dividend is a full-width product of a counter value and a 32-bit clock frequency.
package clock_freq_meter_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LATCH,
    WAIT_LOW,
    WAIT_HIGH,
    MULT,
    DIVIDE,
    DONE
  } state_t;

  localparam int LOCAL_FREQ_WIDTH = 32;

  function automatic int dividend_width(input int counter_width);
    return counter_width + LOCAL_FREQ_WIDTH;
  endfunction

endpackage

// File: rtl/clock_freq_meter_if.sv
// Latch/valid snapshot handshake between the frequency meter (master) and the counter block (slave).
interface clock_freq_meter_if #(
    parameter int COUNTER_WIDTH = 64
) ();

    logic                     latch_counters;
    logic                     counter_valid;
    logic [COUNTER_WIDTH-1:0] clk_local_counter;
    logic [COUNTER_WIDTH-1:0] clk_extern_counter;

    modport master (
        output latch_counters,
        input  counter_valid,
        input  clk_local_counter,
        input  clk_extern_counter
    );

    modport slave (
        input  latch_counters,
        output counter_valid,
        output clk_local_counter,
        output clk_extern_counter
    );

endinterface

// File: rtl/seq_divider.sv
// Restoring unsigned divider, one quotient bit per cycle, MSB first.
// The first step is taken on the start edge, so the quotient is final DIVIDEND_WIDTH edges later.
module seq_divider #(
    parameter int DIVIDEND_WIDTH = 96,
    parameter int DIVISOR_WIDTH  = 64
) (
    input  logic                      i_clk,
    input  logic                      i_rst_n,
    input  logic                      i_start,
    input  logic [DIVIDEND_WIDTH-1:0] i_dividend,
    input  logic [DIVISOR_WIDTH-1:0]  i_divisor,
    output logic                      o_busy,
    output logic                      o_done,
    output logic [DIVIDEND_WIDTH-1:0] o_quotient
);

    localparam int CNT_WIDTH = $clog2(DIVIDEND_WIDTH + 1);

    logic [DIVISOR_WIDTH-1:0]  rem_q, divisor_q;
    logic [DIVIDEND_WIDTH-1:0] quo_q;
    logic [CNT_WIDTH-1:0]      cnt_q;
    logic                      busy_q, done_q;

    logic [DIVISOR_WIDTH-1:0]  src_rem, src_div, rem_next;
    logic [DIVIDEND_WIDTH-1:0] src_quo, quo_next;
    logic [DIVISOR_WIDTH:0]    trial;

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        src_rem  = i_start ? '0 : rem_q;
        src_quo  = i_start ? i_dividend : quo_q;
        src_div  = i_start ? i_divisor : divisor_q;
        trial    = {src_rem, src_quo[DIVIDEND_WIDTH-1]};
        rem_next = trial[DIVISOR_WIDTH-1:0];
        quo_next = {src_quo[DIVIDEND_WIDTH-2:0], 1'b0};
        if (trial >= {1'b0, src_div}) begin
            rem_next = DIVISOR_WIDTH'(trial - {1'b0, src_div});
            quo_next = {src_quo[DIVIDEND_WIDTH-2:0], 1'b1};
        end
    end

    // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            rem_q     <= '0;
            divisor_q <= '0;
            quo_q     <= '0;
            cnt_q     <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (i_start) begin
                rem_q     <= rem_next;
                quo_q     <= quo_next;
                divisor_q <= i_divisor;
                cnt_q     <= CNT_WIDTH'(DIVIDEND_WIDTH - 1);
                busy_q    <= 1'b1;
            end else if (busy_q) begin
                rem_q <= rem_next;
                quo_q <= quo_next;
                cnt_q <= cnt_q - CNT_WIDTH'(1);
                if (cnt_q == CNT_WIDTH'(1)) begin
                    busy_q <= 1'b0;
                    done_q <= 1'b1;
                end
            end
        end
    end

    assign o_busy     = busy_q;
    assign o_done     = done_q;
    assign o_quotient = quo_q;

endmodule

// File: rtl/clock_freq_meter.sv
// Periodically snapshots a local/external counter pair and reports
// f_ext = LOCAL_FREQ_HZ * ext / local in Hz, saturating to FREQ_WIDTH bits.
module clock_freq_meter
    import clock_freq_meter_pkg::*;
#(
    parameter logic [31:0] LOCAL_FREQ_HZ  = 32'd100_000_000,
    parameter int          COUNTER_WIDTH  = 64,
    parameter int          FREQ_WIDTH     = 32,
    parameter int          MEASURE_PERIOD = 1_000_000,
    parameter int          VALID_TIMEOUT  = 1024
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_enable,
    clock_freq_meter_if.master    ctr_bus,
    output logic [FREQ_WIDTH-1:0] o_freq_hz,
    output logic                  o_freq_valid,
    output logic                  o_no_clock,
    output logic                  o_timeout
);

    localparam int DIVIDEND_WIDTH = dividend_width(COUNTER_WIDTH);
    localparam int PERIOD_WIDTH   = $clog2(MEASURE_PERIOD + 1);
    localparam int TIMEOUT_WIDTH  = $clog2(VALID_TIMEOUT + 1);
    localparam logic [PERIOD_WIDTH-1:0]  PERIOD_LAST  = PERIOD_WIDTH'(MEASURE_PERIOD - 1);
    localparam logic [TIMEOUT_WIDTH-1:0] TIMEOUT_LAST = TIMEOUT_WIDTH'(VALID_TIMEOUT - 1);

    state_t                    state_q;
    logic [PERIOD_WIDTH-1:0]   period_cnt_q;
    logic [TIMEOUT_WIDTH-1:0]  timeout_cnt_q;
    logic                      pending_q;
    logic                      latch_q;
    logic [COUNTER_WIDTH-1:0]  local_q, ext_q;

    logic                      period_expired;
    logic                      snap_zero;
    logic                      div_start, div_busy, div_done;
    logic [DIVIDEND_WIDTH-1:0] dividend, div_quotient;
    logic                      quotient_overflow;
    logic [FREQ_WIDTH-1:0]     freq_sat;

    assign period_expired    = i_enable && (period_cnt_q == PERIOD_LAST);
    assign snap_zero         = (local_q == '0) || (ext_q == '0);
    assign dividend          = DIVIDEND_WIDTH'(ext_q) * DIVIDEND_WIDTH'(LOCAL_FREQ_HZ);
    assign div_start         = (state_q == MULT) && !snap_zero;
    assign quotient_overflow = |div_quotient[DIVIDEND_WIDTH-1:FREQ_WIDTH];
    assign freq_sat          = quotient_overflow ? '1 : div_quotient[FREQ_WIDTH-1:0];
    assign ctr_bus.latch_counters = latch_q;

    // Free-running while enabled, independent of the FSM, so requests stay evenly spaced.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            period_cnt_q <= '0;
        end else if (!i_enable || period_expired) begin
            period_cnt_q <= '0;
        end else begin
            period_cnt_q <= period_cnt_q + PERIOD_WIDTH'(1);
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q       <= IDLE;
            timeout_cnt_q <= '0;
            pending_q     <= 1'b0;
            latch_q       <= 1'b0;
            local_q       <= '0;
            ext_q         <= '0;
            o_freq_hz     <= '0;
            o_freq_valid  <= 1'b0;
            o_no_clock    <= 1'b0;
            o_timeout     <= 1'b0;
        end else begin
            latch_q      <= 1'b0;
            o_freq_valid <= 1'b0;
            if (!i_enable) begin
                pending_q <= 1'b0;
            end else if (period_expired && state_q != IDLE) begin
                pending_q <= 1'b1;
            end

            case (state_q)
                IDLE: begin
                    if (i_enable && (period_expired || pending_q)) begin
                        state_q   <= LATCH;
                        latch_q   <= 1'b1;
                        pending_q <= 1'b0;
                    end
                end
                LATCH: begin
                    state_q       <= WAIT_LOW;
                    timeout_cnt_q <= '0;
                end
                WAIT_LOW, WAIT_HIGH: begin
                    // The stale high valid seen right after the request is never taken as data.
                    if (state_q == WAIT_HIGH && ctr_bus.counter_valid) begin
                        local_q <= ctr_bus.clk_local_counter;
                        ext_q   <= ctr_bus.clk_extern_counter;
                        state_q <= MULT;
                    end else if (timeout_cnt_q == TIMEOUT_LAST) begin
                        o_timeout <= 1'b1;
                        state_q   <= IDLE;
                    end else begin
                        timeout_cnt_q <= timeout_cnt_q + TIMEOUT_WIDTH'(1);
                        if (state_q == WAIT_LOW && !ctr_bus.counter_valid) begin
                            state_q <= WAIT_HIGH;
                        end
                    end
                end
                MULT: begin
                    if (snap_zero) begin
                        o_freq_hz    <= '0;
                        o_no_clock   <= 1'b1;
                        o_freq_valid <= 1'b1;
                        state_q      <= IDLE;
                    end else begin
                        state_q <= DIVIDE;
                    end
                end
                DIVIDE: begin
                    if (div_done && !div_busy) begin
                        o_freq_hz    <= freq_sat;
                        o_no_clock   <= 1'b0;
                        o_timeout    <= 1'b0;
                        o_freq_valid <= 1'b1;
                        state_q      <= DONE;
                    end
                end
                DONE:    state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    seq_divider #(
        .DIVIDEND_WIDTH(DIVIDEND_WIDTH),
        .DIVISOR_WIDTH (COUNTER_WIDTH)
    ) u_divider (
        .i_clk     (i_clk),
        .i_rst_n   (i_rst_n),
        .i_start   (div_start),
        .i_dividend(dividend),
        .i_divisor (local_q),
        .o_busy    (div_busy),
        .o_done    (div_done),
        .o_quotient(div_quotient)
    );

endmodule

// File: tb/tb_clock_freq_meter.sv
// Scoreboard bench: a counter-block model answers each latch request from a directed table,
// pushes the expected result, and a negedge monitor pops and compares DUT outputs.
module tb_clock_freq_meter;

    localparam int CW         = 64;
    localparam int PERIOD     = 200;
    localparam int TB_TIMEOUT = 16;
    localparam int LAT_GOOD   = CW + 34;
    localparam int LAT_ZERO   = 2;
    localparam int NVEC       = 12;

    typedef struct {
        logic [CW-1:0] loc;
        logic [CW-1:0] ext;
        int            delay;
        logic          hang;
        logic [31:0]   freq;
        logic          nc;
        logic          to;
    } vec_t;

    typedef struct {
        logic [31:0] freq;
        logic        no_clock;
        logic        timeout;
        int          cyc;
    } exp_t;

    logic        i_clk = 1'b0;
    logic        i_rst_n;
    logic        i_enable;
    logic [31:0] o_freq_hz;
    logic        o_freq_valid, o_no_clock, o_timeout;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int served   = 0;
    int latch_count = 0;
    int fv_count    = 0;
    int hold_violations = 0;
    exp_t exp_q[$];
    exp_t exp_to_q[$];

    vec_t vecs [NVEC] = '{
        '{64'd1000,          64'd0,             3, 1'b0, 32'd0,             1'b1, 1'b0},
        '{64'd1000,          64'd500,           3, 1'b0, 32'd50_000_000,    1'b0, 1'b0},
        '{64'd0,             64'd0,             0, 1'b1, 32'd50_000_000,    1'b0, 1'b1},
        '{64'd0,             64'd7,             2, 1'b0, 32'd0,             1'b1, 1'b1},
        '{64'd3,             64'd1,             2, 1'b0, 32'd33_333_333,    1'b0, 1'b0},
        '{64'd1,             64'd1000,          4, 1'b0, 32'hFFFF_FFFF,     1'b0, 1'b0},
        '{64'd99_999,        64'd12_345,        1, 1'b0, 32'd12_345_123,    1'b0, 1'b0},
        '{64'd100_000_000,   64'd4_294_967_294, 2, 1'b0, 32'd4_294_967_294, 1'b0, 1'b0},
        '{64'h100_0000_0000, 64'h100_0000_0000, 3, 1'b0, 32'd100_000_000,   1'b0, 1'b0},
        '{64'd100_000_000,   64'd4_294_967_296, 2, 1'b0, 32'hFFFF_FFFF,     1'b0, 1'b0},
        '{64'd1000,          64'd250,           2, 1'b0, 32'd25_000_000,    1'b0, 1'b0},
        '{64'd7,             64'd7,             1, 1'b0, 32'd100_000_000,   1'b0, 1'b0}
    };

    clock_freq_meter_if #(.COUNTER_WIDTH(CW)) bus ();

    clock_freq_meter #(
        .LOCAL_FREQ_HZ (32'd100_000_000),
        .COUNTER_WIDTH (CW),
        .FREQ_WIDTH    (32),
        .MEASURE_PERIOD(PERIOD),
        .VALID_TIMEOUT (TB_TIMEOUT)
    ) dut (
        .i_clk       (i_clk),
        .i_rst_n     (i_rst_n),
        .i_enable    (i_enable),
        .ctr_bus     (bus),
        .o_freq_hz   (o_freq_hz),
        .o_freq_valid(o_freq_valid),
        .o_no_clock  (o_no_clock),
        .o_timeout   (o_timeout)
    );

    always #5 i_clk = ~i_clk;

    initial forever begin
        @(posedge i_clk);
        cyc++;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: actual=%0d required=%0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Counter block model: valid drops one edge after the request, rises delay cycles later.
    initial begin : counter_model
        vec_t v;
        int   latch_cyc;
        bus.counter_valid      = 1'b1;
        bus.clk_local_counter  = '0;
        bus.clk_extern_counter = '0;
        forever begin
            @(negedge i_clk);
            if (i_rst_n && bus.latch_counters && served < NVEC) begin
                latch_cyc = cyc;
                v = vecs[served];
                @(posedge i_clk);
                #1;
                bus.counter_valid = 1'b0;
                if (v.hang) begin
                    exp_to_q.push_back(exp_t'{v.freq, v.nc, 1'b1, latch_cyc + TB_TIMEOUT + 1});
                end else begin
                    repeat (v.delay) @(posedge i_clk);
                    #1;
                    bus.clk_local_counter  = v.loc;
                    bus.clk_extern_counter = v.ext;
                    bus.counter_valid      = 1'b1;
                    exp_q.push_back(exp_t'{v.freq, v.nc, v.to, cyc + (v.nc ? LAT_ZERO : LAT_GOOD)});
                end
                served++;
            end
        end
    end

    initial begin : monitor
        exp_t e;
        logic prev_fv = 1'b0, prev_to = 1'b0, prev_latch = 1'b0;
        logic en_break = 1'b1;
        logic [31:0] last_freq = '0;
        int last_latch = 0;
        forever begin
            @(negedge i_clk);
            if (!i_rst_n) begin
                prev_fv = 1'b0; prev_to = 1'b0; prev_latch = 1'b0;
                en_break = 1'b1; last_freq = '0;
            end else begin
                if (prev_fv) check("freq_valid_width", o_freq_valid, 0);
                if (prev_latch) check("latch_width", bus.latch_counters, 0);
                if (o_freq_valid) begin
                    fv_count++;
                    if (exp_q.size() == 0) begin
                        check("unexpected_freq_valid", 1, 0);
                    end else begin
                        e = exp_q.pop_front();
                        check("freq_hz", o_freq_hz, e.freq);
                        check("no_clock", o_no_clock, e.no_clock);
                        check("timeout_flag", o_timeout, e.timeout);
                        check("result_cycle", cyc, e.cyc);
                    end
                    last_freq = o_freq_hz;
                end else if (o_freq_hz !== last_freq) begin
                    hold_violations++;
                end
                if (o_timeout && !prev_to) begin
                    if (exp_to_q.size() == 0) begin
                        check("unexpected_timeout", 1, 0);
                    end else begin
                        e = exp_to_q.pop_front();
                        check("timeout_cycle", cyc, e.cyc);
                        check("freq_held_on_timeout", o_freq_hz, e.freq);
                    end
                end
                if (bus.latch_counters) begin
                    latch_count++;
                    if (!en_break) check("latch_spacing", cyc - last_latch, PERIOD);
                    last_latch = cyc;
                    en_break   = 1'b0;
                end
                if (!i_enable) en_break = 1'b1;
                prev_fv    = o_freq_valid;
                prev_to    = o_timeout;
                prev_latch = bus.latch_counters;
            end
        end
    end

    task automatic wait_results(input int target, input int budget);
        int n = 0;
        while (!(served >= target && exp_q.size() == 0 && exp_to_q.size() == 0) && n < budget) begin
            @(posedge i_clk);
            n++;
        end
        check("results_progress", (served >= target && exp_q.size() == 0 && exp_to_q.size() == 0), 1);
    endtask

    task automatic wait_raised(input int target, input int budget);
        int n = 0;
        while (served < target && n < budget) begin
            @(posedge i_clk);
            n++;
        end
        check("request_progress", served >= target, 1);
    endtask

    initial begin : stimulus
        int lc0, fv0;
        i_rst_n  = 1'b0;
        i_enable = 1'b0;
        repeat (3) @(posedge i_clk);
        #1;
        check("reset_freq_hz", o_freq_hz, 0);
        check("reset_freq_valid", o_freq_valid, 0);
        check("reset_no_clock", o_no_clock, 0);
        check("reset_timeout", o_timeout, 0);
        check("reset_latch", bus.latch_counters, 0);
        i_rst_n = 1'b1;
        @(posedge i_clk);
        #1;
        i_enable = 1'b1;

        wait_results(10, 10 * PERIOD + 800);

        // Disabled: no requests at all.
        @(posedge i_clk);
        #1;
        i_enable = 1'b0;
        lc0 = latch_count;
        repeat (3 * PERIOD) @(posedge i_clk);
        check("no_latch_when_disabled", latch_count - lc0, 0);

        // Reset in the middle of a divide aborts it with no result.
        i_enable = 1'b1;
        wait_raised(11, 2 * PERIOD);
        repeat (40) @(posedge i_clk);
        #3;
        i_rst_n  = 1'b0;
        i_enable = 1'b0;
        #1;
        check("async_reset_freq_hz", o_freq_hz, 0);
        check("async_reset_freq_valid", o_freq_valid, 0);
        check("async_reset_no_clock", o_no_clock, 0);
        check("async_reset_timeout", o_timeout, 0);
        exp_q.delete();
        repeat (3) @(posedge i_clk);
        #1;
        i_rst_n = 1'b1;
        fv0 = fv_count;
        repeat (PERIOD) @(posedge i_clk);
        check("no_valid_after_abort", fv_count - fv0, 0);

        // Recovery measurement after the abort.
        i_enable = 1'b1;
        wait_results(12, 2 * PERIOD + 200);
        i_enable = 1'b0;
        repeat (2) @(posedge i_clk);
        check("freq_hz_stable_between_updates", hold_violations, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin : watchdog
        #500_000;
        $display("FAIL watchdog: simulation did not finish, actual cycle=%0d required below %0d", cyc, 50_000);
        $fatal(1);
    end

endmodule
